// File: rtl/buzzer_scheduler.sv
// Shares one buzzer pin between click, final-melody and error sounds: fixed-priority
// arbitration with preemption, then step-by-step playback of the winner's note table.
module buzzer_scheduler #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_click,
    input  logic       req_final,
    input  logic       req_error,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       done
);

    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned IW   = 2;
    localparam int unsigned SW   = 4;
    localparam int unsigned PERW = 16;
    localparam int unsigned DW   = 10;
    localparam logic [IW-1:0] ID_NONE    = IW'(3);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      pending;
    logic [SW-1:0]   step_idx;
    logic [PW-1:0]   presc;
    logic [DW-1:0]   dur_cnt;
    logic [DW-1:0]   cur_d;
    logic [PERW-1:0] tone_cnt;
    logic [PERW-1:0] cur_p;
    logic            phase;

    // Note tables packed as {half_period, duration_ticks}; half_period 0 is a rest.
    function automatic logic [PERW+DW-1:0] step_lookup(input logic [IW-1:0] sid,
                                                        input logic [SW-1:0] sidx);
        logic [PERW+DW-1:0] s;
        s = '0;
        case (sid)
            2'd0: s = {16'd637, 10'd30};
            2'd1: begin
                case (sidx)
                    4'd0:    s = {16'd758,  10'd210};
                    4'd1:    s = {16'd0,    10'd5};
                    4'd2:    s = {16'd758,  10'd210};
                    4'd3:    s = {16'd0,    10'd220};
                    4'd4:    s = {16'd758,  10'd210};
                    4'd5:    s = {16'd0,    10'd220};
                    4'd6:    s = {16'd955,  10'd210};
                    4'd7:    s = {16'd0,    10'd5};
                    4'd8:    s = {16'd758,  10'd357};
                    4'd9:    s = {16'd0,    10'd72};
                    4'd10:   s = {16'd637,  10'd357};
                    4'd11:   s = {16'd0,    10'd500};
                    4'd12:   s = {16'd1275, 10'd357};
                    default: s = '0;
                endcase
            end
            2'd2: begin
                case (sidx)
                    4'd1:    s = {16'd0,    10'd50};
                    default: s = {16'd1275, 10'd150};
                endcase
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [SW-1:0] last_step(input logic [IW-1:0] sid);
        logic [SW-1:0] l;
        case (sid)
            2'd1:    l = SW'(12);
            2'd2:    l = SW'(2);
            default: l = '0;
        endcase
        return l;
    endfunction

    // Higher rank wins; the idle id ranks lowest so any request beats it.
    function automatic logic [1:0] rank(input logic [IW-1:0] sid);
        logic [1:0] r;
        case (sid)
            2'd1:    r = 2'd3;
            2'd2:    r = 2'd2;
            2'd0:    r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [2:0]    req_vec_c;
    logic [2:0]    active_mask_c;
    logic [2:0]    eff_c;
    logic [IW-1:0] win_id_c;
    logic          start_c;
    logic          step_end_c;
    logic          last_end_c;
    logic          tone_wrap_c;
    logic          phase_next_c;

    always_comb begin
        req_vec_c     = {req_error, req_final, req_click};
        active_mask_c = '0;
        if (state != IDLE) begin
            active_mask_c = 3'b001 << active_id;
        end
        eff_c = pending | (req_vec_c & ~active_mask_c);

        win_id_c = IW'(0);
        if (eff_c[1]) begin
            win_id_c = IW'(1);
        end else if (eff_c[2]) begin
            win_id_c = IW'(2);
        end

        start_c     = (|eff_c) && (rank(win_id_c) > rank(active_id));
        step_end_c  = (presc == PRESC_LAST) && (dur_cnt == cur_d - DW'(1));
        last_end_c  = step_end_c && (step_idx == last_step(active_id));
        tone_wrap_c = (tone_cnt == cur_p - PERW'(1));

        // Phase holds across the load gap and preemption, clears when a step starts playing.
        phase_next_c = phase;
        if (state == IDLE) begin
            phase_next_c = 1'b0;
        end else if (start_c) begin
            phase_next_c = phase;
        end else if (state == LOAD) begin
            phase_next_c = 1'b0;
        end else if (step_end_c) begin
            phase_next_c = last_end_c ? 1'b0 : phase;
        end else if ((cur_p != '0) && tone_wrap_c) begin
            phase_next_c = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            step_idx  <= '0;
            presc     <= '0;
            dur_cnt   <= '0;
            cur_d     <= '0;
            tone_cnt  <= '0;
            cur_p     <= '0;
            phase     <= 1'b0;
            beep      <= 1'b0;
            busy      <= 1'b0;
            active_id <= ID_NONE;
            done      <= 1'b0;
        end else begin
            done    <= 1'b0;
            pending <= eff_c;
            phase   <= phase_next_c;
            beep    <= phase_next_c & ~mute;

            if (start_c) begin
                state     <= LOAD;
                active_id <= win_id_c;
                busy      <= 1'b1;
                step_idx  <= '0;
                pending   <= eff_c & ~(3'b001 << win_id_c);
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    LOAD: begin
                        {cur_p, cur_d} <= step_lookup(active_id, step_idx);
                        presc    <= '0;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        state    <= PLAY;
                    end
                    PLAY: begin
                        if (last_end_c) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            active_id <= ID_NONE;
                            done      <= 1'b1;
                            step_idx  <= '0;
                        end else if (step_end_c) begin
                            step_idx <= step_idx + SW'(1);
                            state    <= LOAD;
                        end else begin
                            if (presc == PRESC_LAST) begin
                                presc   <= '0;
                                dur_cnt <= dur_cnt + DW'(1);
                            end else begin
                                presc <= presc + PW'(1);
                            end
                            if ((cur_p == '0) || tone_wrap_c) begin
                                tone_cnt <= '0;
                            end else begin
                                tone_cnt <= tone_cnt + PERW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Randomized and directed bench for buzzer_scheduler: a per-cycle reference model pushes
// expected outputs into a scoreboard queue that a negedge monitor drains and compares.
module tb_buzzer_scheduler;

    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_click;
    logic       req_final;
    logic       req_error;
    logic       mute;
    logic       beep;
    logic       busy;
    logic [1:0] active_id;
    logic       done;

    buzzer_scheduler #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_click (req_click),
        .req_final (req_final),
        .req_error (req_error),
        .mute      (mute),
        .beep      (beep),
        .busy      (busy),
        .active_id (active_id),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       busy;
        logic [1:0] id;
        logic       done;
        logic       beep;
    } exp_t;

    exp_t q[$];
    int   dc_q[$];
    int   total = 0;
    int   bad = 0;

    int fin_p[13] = '{758, 0, 758, 0, 758, 0, 955, 0, 758, 0, 637, 0, 1275};
    int fin_d[13] = '{210, 5, 210, 220, 210, 220, 210, 5, 357, 72, 357, 500, 357};
    int err_p[3]  = '{1275, 0, 1275};
    int err_d[3]  = '{150, 50, 150};

    function automatic int step_p(int id, int s);
        if (id == 0) return 637;
        if (id == 1) return fin_p[s];
        return err_p[s];
    endfunction

    function automatic int step_d(int id, int s);
        if (id == 0) return 30;
        if (id == 1) return fin_d[s];
        return err_d[s];
    endfunction

    function automatic int n_steps(int id);
        if (id == 0) return 1;
        if (id == 1) return 13;
        return 3;
    endfunction

    function automatic int prio(int id);
        if (id == 1) return 3;
        if (id == 2) return 2;
        if (id == 0) return 1;
        return 0;
    endfunction

    // Model: current sound, step, position in step (0 = load cycle), pending set.
    int m_id = 3;
    int m_step = 0;
    int m_pos = 0;
    int m_phase = 0;
    int m_done = 0;
    bit m_pend[3] = '{0, 0, 0};

    always @(posedge clk) begin
        bit   rq[3];
        bit   eff[3];
        int   w;
        int   p;
        exp_t e;
        rq[0] = req_click;
        rq[1] = req_final;
        rq[2] = req_error;
        m_done = 0;
        if (rst) begin
            m_id = 3; m_step = 0; m_pos = 0; m_phase = 0;
            for (int i = 0; i < 3; i++) m_pend[i] = 0;
        end else begin
            for (int i = 0; i < 3; i++) eff[i] = m_pend[i] | (rq[i] && m_id != i);
            w = eff[1] ? 1 : eff[2] ? 2 : eff[0] ? 0 : -1;
            if (w >= 0 && prio(w) > prio(m_id)) begin
                m_id = w; m_step = 0; m_pos = 0; eff[w] = 0;
            end else if (m_id != 3) begin
                if (m_pos == step_d(m_id, m_step) * TD) begin
                    if (m_step == n_steps(m_id) - 1) begin
                        m_done = 1; m_id = 3; m_step = 0; m_pos = 0;
                    end else begin
                        m_step++; m_pos = 0;
                    end
                end else begin
                    m_pos++;
                end
            end
            for (int i = 0; i < 3; i++) m_pend[i] = eff[i];
            if (m_id == 3) begin
                m_phase = 0;
            end else if (m_pos != 0) begin
                p = step_p(m_id, m_step);
                m_phase = (p == 0) ? 0 : ((m_pos - 1) / p) % 2;
            end
        end
        e.busy = (m_id != 3);
        e.id   = 2'(m_id);
        e.done = (m_done != 0);
        e.beep = (m_phase != 0) && !mute && !rst;
        q.push_back(e);
    end

    int cyc_n = 0;
    int done_seen = 0;
    int dc_base = 0;

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc_n, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   want;
        if (q.size() > 0) begin
            e = q.pop_front();
            cyc_n++;
            chk("busy", {1'b0, busy}, {1'b0, e.busy});
            chk("active_id", active_id, e.id);
            chk("done", {1'b0, done}, {1'b0, e.done});
            chk("beep", {1'b0, beep}, {1'b0, e.beep});
            if (done === 1'b1) done_seen++;
        end
        if (dc_q.size() > 0) begin
            want = dc_q.pop_front();
            total++;
            if (done_seen - dc_base != want) begin
                bad++;
                $display("FAIL done_count cycle=%0d got=%0d want=%0d", cyc_n, done_seen - dc_base, want);
            end
            dc_base = done_seen;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic c, input logic f, input logic e);
        req_click = c; req_final = f; req_error = e;
        @(negedge clk);
        req_click = 1'b0; req_final = 1'b0; req_error = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1; mute = 1'b0;
        req_click = 1'b0; req_final = 1'b0; req_error = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(5);

        // single click
        pulse(1'b1, 1'b0, 1'b0);
        cyc(330);
        dc_q.push_back(1);
        cyc(2);

        // error alarm with its rest step
        pulse(1'b0, 1'b0, 1'b1);
        cyc(3600);
        dc_q.push_back(1);
        cyc(2);

        // click preempted by final; retrigger and mute during the melody
        pulse(1'b1, 1'b0, 1'b0);
        cyc(99);
        pulse(1'b0, 1'b1, 1'b0);
        cyc(5000);
        pulse(1'b0, 1'b1, 1'b0);
        cyc(5000);
        mute = 1'b1;
        cyc(2000);
        mute = 1'b0;
        cyc(17600);
        dc_q.push_back(1);
        cyc(2);

        // simultaneous click and error
        pulse(1'b1, 1'b0, 1'b1);
        cyc(3950);
        dc_q.push_back(2);
        cyc(2);

        // reset during step 5 of the melody with a click pending
        pulse(1'b0, 1'b1, 1'b0);
        cyc(2000);
        pulse(1'b1, 1'b0, 1'b0);
        cyc(7000);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(500);
        dc_q.push_back(0);
        cyc(2);

        // random requests, mute and occasional reset
        for (int i = 0; i < 15000; i++) begin
            r = int'($urandom_range(0, 999));
            req_click = (r < 2);
            req_error = (r == 2 || r == 3);
            req_final = (r == 4) && ($urandom_range(0, 3) == 0);
            rst       = (r == 5) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) mute = ~mute;
            cyc(1);
        end
        req_click = 1'b0; req_final = 1'b0; req_error = 1'b0;
        rst = 1'b0; mute = 1'b0;
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
